mem_access_unit: RTL and testbench

- Memory stage of the rv32i core. It sits directly downstream of the execute-stage ALU and consumes its result (the effective address for loads and stores), rs2 data and the decoded opcode/funct3.
- Loads and stores go to a data memory over a valid/ready request channel and a valid-only response channel.
- Load data is aligned and sign/zero-extended. Non-memory results pass through unchanged.
- The unit produces one writeback record per accepted instruction and back-pressures execute while a memory access is in flight.

---
 rtl/mem_access_unit_pkg.sv | 17 +
 rtl/mem_access_unit_load_align.sv | 20 ++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 tb/tb_mem_access_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: opcodes, load/store funct3 encodings and FSM states for the memory stage.
package mem_access_unit_pkg;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [2:0] LSU_FUNCT3_LB  = 3'b000;
  localparam logic [2:0] LSU_FUNCT3_LH  = 3'b001;
  localparam logic [2:0] LSU_FUNCT3_LW  = 3'b010;
  localparam logic [2:0] LSU_FUNCT3_LBU = 3'b100;
  localparam logic [2:0] LSU_FUNCT3_LHU = 3'b101;
  localparam logic [2:0] LSU_FUNCT3_SB  = 3'b000;
  localparam logic [2:0] LSU_FUNCT3_SH  = 3'b001;
  localparam logic [2:0] LSU_FUNCT3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} mau_state_e;
endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: selects the addressed byte/halfword of a raw load word and sign/zero-extends it.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);
  logic [7:0]  bt;
  logic [15:0] half;
  logic        sgn;
  assign bt   = word_i[{lane_i, 3'b000} +: 8];
  assign half = lane_i[1] ? word_i[31:16] : word_i[15:0];
  assign sgn  = funct3_i != LSU_FUNCT3_LBU && funct3_i != LSU_FUNCT3_LHU;
  always_comb
    data_o = funct3_i[1]         ? word_i :
             funct3_i[0]         ? {{16{half[15] & sgn}}, half} :
                                   {{24{bt[7] & sgn}}, bt};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: rv32i memory stage; issues data-memory requests, aligns loads and emits one
// registered writeback record per accepted instruction.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  input  logic              dmem_rsp_valid_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic              misalign_o
);
  mau_state_e        state_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [4:0]        rd_q;
  logic              is_ld, is_st, f3_ok, mis_d;
  logic [1:0]        a;
  logic [3:0]        be_d;
  logic [DWIDTH-1:0] wdata_d, ld_val;

  assign a     = alu_res_i[1:0];
  assign is_ld = opcode_i == OPCODE_LOAD;
  assign is_st = opcode_i == OPCODE_STORE;
  assign f3_ok = is_ld ? funct3_i inside {LSU_FUNCT3_LB, LSU_FUNCT3_LH, LSU_FUNCT3_LW,
                                          LSU_FUNCT3_LBU, LSU_FUNCT3_LHU}
                       : funct3_i inside {LSU_FUNCT3_SB, LSU_FUNCT3_SH, LSU_FUNCT3_SW};
  // Unsupported widths are reported through the misalign path so they never reach memory.
  assign mis_d = !f3_ok || (funct3_i[1:0] == 2'b01 && a[0]) || (funct3_i[1:0] == 2'b10 && a != 2'b00);
  assign be_d  = !is_st                  ? 4'b1111 :
                 funct3_i[1:0] == 2'b00  ? 4'b0001 << a :
                 funct3_i[1:0] == 2'b01  ? 4'b0011 << a : 4'b1111;
  assign wdata_d = funct3_i[1:0] == 2'b00 ? {4{rs2_i[7:0]}} :
                   funct3_i[1:0] == 2'b01 ? {2{rs2_i[15:0]}} : rs2_i;
  assign ex_ready_o = state_q == IDLE;

  load_align u_align (
    .funct3_i (funct3_q),
    .lane_i   (lane_q),
    .word_i   (dmem_rdata_i),
    .data_o   (ld_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      funct3_q         <= '0;
      lane_q           <= '0;
      rd_q             <= '0;
      dmem_req_valid_o <= 1'b0;
      dmem_addr_o      <= '0;
      dmem_we_o        <= 1'b0;
      dmem_be_o        <= '0;
      dmem_wdata_o     <= '0;
      wb_valid_o       <= 1'b0;
      wb_we_o          <= 1'b0;
      wb_rd_o          <= '0;
      wb_data_o        <= '0;
      misalign_o       <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (state_q)
        IDLE: if (ex_valid_i) begin
          funct3_q <= funct3_i;
          lane_q   <= a;
          rd_q     <= rd_i;
          if (!(is_ld || is_st)) begin
            wb_valid_o <= 1'b1;
            wb_we_o    <= opcode_i != OPCODE_BRANCH && rd_i != 5'd0;
            wb_rd_o    <= rd_i;
            wb_data_o  <= alu_res_i;
          end else if (mis_d) begin
            wb_valid_o <= 1'b1;
            misalign_o <= 1'b1;
            wb_rd_o    <= rd_i;
            wb_data_o  <= '0;
          end else begin
            state_q          <= REQ;
            dmem_req_valid_o <= 1'b1;
            dmem_addr_o      <= {alu_res_i[AWIDTH-1:2], 2'b00};
            dmem_we_o        <= is_st;
            dmem_be_o        <= be_d;
            dmem_wdata_o     <= wdata_d;
          end
        end
        REQ: if (dmem_req_ready_i) begin
          dmem_req_valid_o <= 1'b0;
          state_q          <= dmem_we_o ? IDLE : WAIT_RSP;
          if (dmem_we_o) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= rd_q;
            wb_data_o  <= '0;
          end
        end
        WAIT_RSP: if (dmem_rsp_valid_i) begin
          state_q    <= IDLE;
          wb_valid_o <= 1'b1;
          wb_we_o    <= rd_q != 5'd0;
          wb_rd_o    <= rd_q;
          wb_data_o  <= ld_val;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of pass-through, loads, stores, misalign and mid-op reset.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic        clk = 0, reset = 1;
  logic        ex_valid = 0, ex_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] alu_res = '0, rs2 = '0;
  logic [4:0]  rd = '0;
  logic        req_valid, req_ready = 0, we, rsp_valid = 0;
  logic [31:0] addr, wdata, rdata = '0, wb_data;
  logic [3:0]  be;
  logic        wb_valid, wb_we, misalign;
  logic [4:0]  wb_rd;
  int checks = 0, errors = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .opcode_i(opcode), .funct3_i(funct3), .alu_res_i(alu_res), .rs2_i(rs2), .rd_i(rd),
    .dmem_req_valid_o(req_valid), .dmem_req_ready_i(req_ready), .dmem_addr_o(addr),
    .dmem_we_o(we), .dmem_be_o(be), .dmem_wdata_o(wdata),
    .dmem_rsp_valid_i(rsp_valid), .dmem_rdata_i(rdata),
    .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] d2, input logic [4:0] r);
    ex_valid = 1; opcode = op; funct3 = f3; alu_res = ad; rs2 = d2; rd = r;
    tick;
    ex_valid = 0;
  endtask

  task automatic do_load(input string t, input logic [2:0] f3, input logic [31:0] ad,
                         input logic [4:0] r, input logic [31:0] word,
                         input logic [31:0] exp, input logic expwe);
    req_ready = 1;
    issue(OPCODE_LOAD, f3, ad, 32'h0, r);
    check({t, "_req_valid"}, 32'(req_valid), 1);
    check({t, "_addr"}, addr, {ad[31:2], 2'b00});
    check({t, "_be"}, 32'(be), 4'b1111);
    check({t, "_we"}, 32'(we), 0);
    check({t, "_ex_ready"}, 32'(ex_ready), 0);
    tick;
    check({t, "_req_drop"}, 32'(req_valid), 0);
    check({t, "_no_early_wb"}, 32'(wb_valid), 0);
    rsp_valid = 1; rdata = word;
    tick;
    rsp_valid = 0; req_ready = 0;
    check({t, "_wb_valid"}, 32'(wb_valid), 1);
    check({t, "_wb_we"}, 32'(wb_we), 32'(expwe));
    check({t, "_wb_rd"}, 32'(wb_rd), 32'(r));
    check({t, "_wb_data"}, wb_data, exp);
    tick;
    check({t, "_wb_pulse"}, 32'(wb_valid), 0);
  endtask

  initial begin
    #3;
    check("rst_ex_ready", 32'(ex_ready), 1);
    check("rst_req_valid", 32'(req_valid), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_data", wb_data, 0);
    @(negedge clk);
    reset = 0;
    tick;

    issue(OPCODE_OP, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    check("add_wb_valid", 32'(wb_valid), 1);
    check("add_wb_we", 32'(wb_we), 1);
    check("add_wb_rd", 32'(wb_rd), 5);
    check("add_wb_data", wb_data, 32'h0000_1234);
    check("add_no_req", 32'(req_valid), 0);
    ex_valid = 1; opcode = OPCODE_OPIMM; alu_res = 32'hCAFE_0001; rd = 5'd9;
    tick;
    check("b2b1_data", wb_data, 32'hCAFE_0001);
    opcode = OPCODE_BRANCH; alu_res = 32'h0000_0055; rd = 5'd4;
    tick;
    ex_valid = 0;
    check("br_wb_valid", 32'(wb_valid), 1);
    check("br_wb_we", 32'(wb_we), 0);
    check("br_wb_data", wb_data, 32'h0000_0055);
    tick;
    check("br_pulse", 32'(wb_valid), 0);

    do_load("lb", LSU_FUNCT3_LB, 32'h103, 5'd7, 32'h80FF_00AA, 32'hFFFF_FF80, 1);
    do_load("lbu", LSU_FUNCT3_LBU, 32'h103, 5'd7, 32'h80FF_00AA, 32'h0000_0080, 1);
    do_load("lh", LSU_FUNCT3_LH, 32'h102, 5'd8, 32'h80FF_00AA, 32'hFFFF_80FF, 1);
    do_load("lhu", LSU_FUNCT3_LHU, 32'h100, 5'd8, 32'h80FF_90AA, 32'h0000_90AA, 1);
    do_load("lw_rd0", LSU_FUNCT3_LW, 32'h400, 5'd0, 32'h1234_5678, 32'h1234_5678, 0);

    req_ready = 0;
    issue(OPCODE_STORE, LSU_FUNCT3_SH, 32'h202, 32'hDEAD_BEEF, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("sh_req_valid", 32'(req_valid), 1);
      check("sh_addr", addr, 32'h200);
      check("sh_be", 32'(be), 4'b1100);
      check("sh_wdata", wdata, 32'hBEEF_BEEF);
      check("sh_we", 32'(we), 1);
      check("sh_ex_ready", 32'(ex_ready), 0);
      check("sh_no_wb", 32'(wb_valid), 0);
      tick;
    end
    req_ready = 1;
    tick;
    req_ready = 0;
    check("sh_wb_valid", 32'(wb_valid), 1);
    check("sh_wb_we", 32'(wb_we), 0);
    check("sh_req_drop", 32'(req_valid), 0);
    check("sh_ex_ready_back", 32'(ex_ready), 1);

    req_ready = 1;
    issue(OPCODE_STORE, LSU_FUNCT3_SB, 32'h001, 32'h0000_00A5, 5'd0);
    check("sb_be", 32'(be), 4'b0010);
    check("sb_wdata", wdata, 32'hA5A5_A5A5);
    tick;
    req_ready = 0;
    check("sb_wb_valid", 32'(wb_valid), 1);

    tick;
    issue(OPCODE_LOAD, LSU_FUNCT3_LW, 32'h301, 32'h0, 5'd6);
    check("mis_req_valid", 32'(req_valid), 0);
    check("mis_flag", 32'(misalign), 1);
    check("mis_wb_valid", 32'(wb_valid), 1);
    check("mis_wb_we", 32'(wb_we), 0);
    check("mis_wb_data", wb_data, 0);
    check("mis_ex_ready", 32'(ex_ready), 1);
    tick;
    check("mis_pulse", 32'(misalign), 0);
    issue(OPCODE_LOAD, 3'b011, 32'h100, 32'h0, 5'd6);
    check("badf3_flag", 32'(misalign), 1);
    check("badf3_req", 32'(req_valid), 0);
    issue(OPCODE_STORE, LSU_FUNCT3_SH, 32'h203, 32'h0, 5'd0);
    check("sh_mis_flag", 32'(misalign), 1);

    req_ready = 1;
    issue(OPCODE_LOAD, LSU_FUNCT3_LW, 32'h400, 32'h0, 5'd3);
    tick;
    req_ready = 0;
    check("rstw_ex_ready", 32'(ex_ready), 0);
    #1 reset = 1;
    #1;
    check("rstw_ex_ready_async", 32'(ex_ready), 1);
    check("rstw_req_valid", 32'(req_valid), 0);
    check("rstw_wb_valid", 32'(wb_valid), 0);
    tick;
    reset = 0;
    tick;
    check("rstw_no_spurious", 32'(wb_valid), 0);
    issue(OPCODE_OP, 3'b000, 32'h0000_00AB, 32'h0, 5'd2);
    check("rstw_add_valid", 32'(wb_valid), 1);
    check("rstw_add_data", wb_data, 32'h0000_00AB);
    check("rstw_add_rd", 32'(wb_rd), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
